counter_mod_updown: RTL and testbench

COUNTER_MOD_UPDOWN -- requirements
Module: counter_mod_updown

---
 rtl/counter_mod_updown.sv | 54 +++++
 tb/tb_counter_mod_updown.sv | 138 +++++++++++++
 2 files changed

// File: rtl/counter_mod_updown.sv
// counter_mod_updown: modulo-MOD_VALUE up/down counter with clear, clamped load, terminal count and wrap pulse
// Build option: define COUNTER_MOD_SAT_EN to saturate at the boundaries instead of wrapping.
module counter_mod_updown #(
    parameter int CNT_WIDTH = 3,
    parameter int MOD_VALUE = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 up_dn,
    input  logic                 clear,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    output logic [CNT_WIDTH-1:0] counter,
    output logic                 tc,
    output logic                 wrap
);
    localparam int MAX_I = MOD_VALUE - 1;
    localparam logic [CNT_WIDTH:0] MAX_V = MAX_I[CNT_WIDTH:0];
    localparam logic [CNT_WIDTH:0] ONE = {{CNT_WIDTH{1'b0}}, 1'b1};
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 wrap_q, wrap_d;
    logic [CNT_WIDTH:0]   cnt_x, ld_x, step_x, next_x;
    logic                 at_top, at_zero;
    // One bit of headroom keeps the MOD_VALUE-1 compare exact when MOD_VALUE = 2^CNT_WIDTH
    always_comb begin
        cnt_x = {1'b0, cnt_q};
        ld_x = {1'b0, load_val};
        at_top = cnt_x == MAX_V;
        at_zero = cnt_x == '0;
        tc = en & (up_dn ? at_top : at_zero);
`ifdef COUNTER_MOD_SAT_EN
        step_x = up_dn ? (at_top ? MAX_V : cnt_x + ONE) : (at_zero ? '0 : cnt_x - ONE);
        wrap_d = 1'b0;
`else
        step_x = up_dn ? (at_top ? '0 : cnt_x + ONE) : (at_zero ? MAX_V : cnt_x - ONE);
        wrap_d = tc & ~clear & ~load;
`endif
        next_x = clear ? '0 : load ? (ld_x > MAX_V ? MAX_V : ld_x) : en ? step_x : cnt_x;
        cnt_d = next_x[CNT_WIDTH-1:0];
    end
    // Count and wrap-pulse registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            wrap_q <= wrap_d;
        end
    end
    assign counter = cnt_q;
    assign wrap = wrap_q;
endmodule

// File: tb/tb_counter_mod_updown.sv
// tb_counter_mod_updown: scoreboard bench for counter_mod_updown (CNT_WIDTH=4, MOD_VALUE=10)
module tb_counter_mod_updown;
    localparam int W = 4;
    localparam int M = 10;
`ifdef COUNTER_MOD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    typedef struct {
        int c;
        int w;
        int t;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         en = 1'b0;
    logic         up_dn = 1'b0;
    logic         clear = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] counter;
    logic         tc;
    logic         wrap;

    exp_t q[$];
    int   m_cnt = 0;
    int   n_vec = 0;
    int   n_err = 0;

    counter_mod_updown #(.CNT_WIDTH(W), .MOD_VALUE(M)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .en(en),
        .up_dn(up_dn),
        .clear(clear),
        .load(load),
        .load_val(load_val),
        .counter(counter),
        .tc(tc),
        .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and push the behavioural expectation for the following edge
    task automatic step(input bit e, input bit u, input bit c, input bit l, input int lv);
        exp_t x;
        int   nc;
        bit   tc_now;
        @(negedge clk);
        en = e;
        up_dn = u;
        clear = c;
        load = l;
        load_val = lv[W-1:0];
        tc_now = e && (u ? (m_cnt == M - 1) : (m_cnt == 0));
        if (c) nc = 0;
        else if (l) nc = (lv >= M) ? M - 1 : lv;
        else if (e && u) nc = SAT ? ((m_cnt + 1 > M - 1) ? M - 1 : m_cnt + 1) : (m_cnt + 1) % M;
        else if (e) nc = SAT ? ((m_cnt - 1 < 0) ? 0 : m_cnt - 1) : (m_cnt + M - 1) % M;
        else nc = m_cnt;
        x.c = nc;
        x.w = (!SAT && tc_now && !c && !l) ? 1 : 0;
        x.t = (e && (u ? (nc == M - 1) : (nc == 0))) ? 1 : 0;
        m_cnt = nc;
        q.push_back(x);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        en = 1'b0;
        clear = 1'b0;
        load = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk({nm, "_counter"}, int'(counter), 0);
        chk({nm, "_wrap"}, int'(wrap), 0);
        @(negedge clk);
        reset_n = 1'b1;
        m_cnt = 0;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("counter", int'(counter), x.c);
                chk("wrap", int'(wrap), x.w);
                chk("tc", int'(tc), x.t);
            end
        end
    end

    initial begin : driver
        #3;
        chk("reset_counter", int'(counter), 0);
        chk("reset_wrap", int'(wrap), 0);
        @(negedge clk);
        reset_n = 1'b1;
        step(0, 1, 1, 0, 0);
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 2);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        step(0, 1, 1, 1, 5);
        step(0, 1, 0, 1, 13);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, i[0], 0, 0, 0);
        step(0, 1, 1, 0, 0);
        for (int i = 0; i < 15; i++) step(1, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 14) == 0, int'($urandom_range(0, 15)));
        step(0, 1, 0, 1, 6);
        do_reset("rst_mid");
        step(0, 1, 0, 1, 9);
        step(1, 1, 0, 0, 0);
        do_reset("rst_wrap");
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) @(negedge clk);
        chk("queue_drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
